// File: rtl/if_pc_unit.sv
// ---------------------------------------------------------------------------
// if_pc_unit -- program-counter unit for the instruction-fetch stage.
//
// Produces the fetch PC every cycle, choosing between a sequential increment,
// a branch redirect and a jump redirect. A global enable, a hazard stall and
// a sticky RUN/HALTED state machine gate PC updates. A saturating count of PC
// advances and a sticky redirect-misalignment flag are exported for debug.
//
// Optional feature (compile-time macro STEP_EN): when defined, an i_step
// pulse while HALTED (with i_enable=1) performs one next-PC evaluation using
// the RUN priority rules while the unit stays HALTED. When undefined, i_step
// is ignored and HALTED is left only through reset.
//
// Parameters:
//   PC_WIDTH  - width of all PC / target buses
//   RESET_PC  - PC loaded on reset (PC_STEP aligned)
//   PC_STEP   - sequential increment (power of two, >= 1)
//   CNT_WIDTH - width of the saturating fetch counter
//
// Ports:
//   i_clk, i_reset         - rising-edge clock, async active-high reset
//   i_enable               - global run enable; 0 holds everything
//   i_stall                - hazard stall; holds PC unless redirected
//   i_halt                 - enter HALTED (PC not updated on that edge)
//   i_branch_taken/_target - branch redirect (highest priority)
//   i_jump/_target         - jump redirect
//   i_step                 - single-step pulse (STEP_EN builds only)
//   o_pc                   - registered fetch PC
//   o_pc_plus              - o_pc + PC_STEP
//   o_valid                - o_pc is a live fetch this cycle
//   o_halted               - unit is HALTED
//   o_misalign             - sticky: a redirect target had low bits set
//   o_fetch_cnt            - saturating count of PC advances
// ---------------------------------------------------------------------------
module if_pc_unit #(
    parameter int                     PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC  = {PC_WIDTH{1'b0}},
    parameter int                     PC_STEP   = 4,
    parameter int                     CNT_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_stall,
    input  logic                      i_halt,
    input  logic                      i_branch_taken,
    input  logic [PC_WIDTH-1:0]       i_branch_target,
    input  logic                      i_jump,
    input  logic [PC_WIDTH-1:0]       i_jump_target,
    input  logic                      i_step,
    output logic [PC_WIDTH-1:0]       o_pc,
    output logic [PC_WIDTH-1:0]       o_pc_plus,
    output logic                      o_valid,
    output logic                      o_halted,
    output logic                      o_misalign,
    output logic [CNT_WIDTH-1:0]      o_fetch_cnt
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    localparam logic [PC_WIDTH-1:0]  STEP_VEC = PC_WIDTH'(PC_STEP);
    // Bits below the step granularity; all zero when PC_STEP == 1, which
    // naturally disables both masking and misalignment detection.
    localparam logic [PC_WIDTH-1:0]  LOW_MASK = PC_WIDTH'(PC_STEP - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    // Clear the sub-step bits of a redirect target.
    function automatic logic [PC_WIDTH-1:0] align_target(input logic [PC_WIDTH-1:0] t);
        return t & ~LOW_MASK;
    endfunction

    // True when a redirect target would have been truncated by alignment.
    function automatic logic target_misaligned(input logic [PC_WIDTH-1:0] t);
        return |(t & LOW_MASK);
    endfunction

    logic [0:0]           state_r;
    logic [PC_WIDTH-1:0]  pc_r;
    logic                 misalign_r;
    logic [CNT_WIDTH-1:0] cnt_r;

    logic [0:0]           next_state_s;
    logic [PC_WIDTH-1:0]  next_pc_s;
    logic [PC_WIDTH-1:0]  pc_plus_s;
    logic [PC_WIDTH-1:0]  raw_target_s;
    logic                 redirect_s;
    logic                 step_req_s;
    logic                 eval_s;
    logic                 advance_s;
    logic                 set_misalign_s;
    logic                 valid_s;

`ifdef STEP_EN
    assign step_req_s = i_step;
`else
    // Step is architecturally ignored in this build.
    assign step_req_s = i_step & 1'b0;
`endif

    // Next-PC evaluation, halt transition, advance and flag qualifiers.
    always_comb begin
        pc_plus_s      = pc_r + STEP_VEC;
        redirect_s     = i_branch_taken | i_jump;
        raw_target_s   = i_branch_taken ? i_branch_target : i_jump_target;
        eval_s         = 1'b0;
        next_state_s   = state_r;
        valid_s        = 1'b0;
        case (state_r)
            ST_RUN: begin
                // Halt wins over any redirect or increment on its edge.
                eval_s  = i_enable & ~i_halt;
                valid_s = i_enable & ~i_stall & ~i_reset;
                if (i_enable && i_halt) begin
                    next_state_s = ST_HALTED;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_HALTED: begin
                eval_s       = i_enable & step_req_s;
                valid_s      = i_enable & step_req_s & ~i_stall & ~i_reset;
                next_state_s = ST_HALTED;
            end
            default: begin
                eval_s       = 1'b0;
                valid_s      = 1'b0;
                next_state_s = ST_RUN;
            end
        endcase

        // A redirect overrides a stall and counts even if it targets o_pc.
        if (eval_s && redirect_s) begin
            next_pc_s = align_target(raw_target_s);
        end else if (eval_s && !i_stall) begin
            next_pc_s = pc_plus_s;
        end else begin
            next_pc_s = pc_r;
        end
        advance_s      = eval_s & (redirect_s | ~i_stall);
        set_misalign_s = eval_s & redirect_s & target_misaligned(raw_target_s);
    end

    // State, PC, sticky misalignment flag and saturating fetch counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r    <= ST_RUN;
            pc_r       <= RESET_PC;
            misalign_r <= 1'b0;
            cnt_r      <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r    <= next_state_s;
            pc_r       <= next_pc_s;
            misalign_r <= misalign_r | set_misalign_s;
            if (advance_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign o_pc        = pc_r;
    assign o_pc_plus   = pc_plus_s;
    assign o_valid     = valid_s;
    assign o_halted    = (state_r == ST_HALTED);
    assign o_misalign  = misalign_r;
    assign o_fetch_cnt = cnt_r;

endmodule

// File: tb/tb_if_pc_unit.sv
// Bench for if_pc_unit: two instances (32-bit PC / 16-bit counter and
// 8-bit PC / 2-bit counter) share one stimulus stream. A behavioural model
// built from modular arithmetic tracks both; a compare process checks every
// output of both instances each cycle, and directed literal checks pin the
// model on the documented scenarios before a randomized phase.
module tb_if_pc_unit;

    localparam longint unsigned STEP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, stall = 1'b0, halt = 1'b0, br = 1'b0, jp = 1'b0, step = 1'b0;
    logic [31:0] bt = 32'h0, jt = 32'h0;

    logic [31:0] pc0, pcp0;
    logic        v0, h0, mi0;
    logic [15:0] c0;
    logic [7:0]  pc1, pcp1;
    logic        v1, h1, mi1;
    logic [1:0]  c1;

    int total = 0;
    int passed = 0;

    if_pc_unit #(.PC_WIDTH(32), .RESET_PC(32'h100), .PC_STEP(4), .CNT_WIDTH(16)) u0 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_stall(stall), .i_halt(halt),
        .i_branch_taken(br), .i_branch_target(bt), .i_jump(jp), .i_jump_target(jt),
        .i_step(step), .o_pc(pc0), .o_pc_plus(pcp0), .o_valid(v0), .o_halted(h0),
        .o_misalign(mi0), .o_fetch_cnt(c0));

    if_pc_unit #(.PC_WIDTH(8), .RESET_PC(8'hF8), .PC_STEP(4), .CNT_WIDTH(2)) u1 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_stall(stall), .i_halt(halt),
        .i_branch_taken(br), .i_branch_target(bt[7:0]), .i_jump(jp), .i_jump_target(jt[7:0]),
        .i_step(step), .o_pc(pc1), .o_pc_plus(pcp1), .o_valid(v1), .o_halted(h1),
        .o_misalign(mi1), .o_fetch_cnt(c1));

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        longint unsigned pc;
        bit              halted;
        bit              mis;
        longint unsigned cnt;
    } mstate_t;

    mstate_t m [2];

    function automatic longint unsigned pc_mod(int k);
        return (k == 0) ? (64'd1 << 32) : (64'd1 << 8);
    endfunction

    function automatic longint unsigned cnt_max(int k);
        return (k == 0) ? 64'd65535 : 64'd3;
    endfunction

    function automatic mstate_t reset_state(int k);
        mstate_t s;
        s.pc = (k == 0) ? 64'h100 : 64'hF8;
        s.halted = 1'b0;
        s.mis = 1'b0;
        s.cnt = 64'd0;
        return s;
    endfunction

    function automatic mstate_t next_state(int k, mstate_t s);
        mstate_t n = s;
        bit run_eval;
        longint unsigned t;
        if (!en) return n;
        if (!s.halted && halt) begin
            n.halted = 1'b1;
            return n;
        end
        run_eval = !s.halted;
`ifdef STEP_EN
        if (s.halted && step) run_eval = 1'b1;
`endif
        if (!run_eval) return n;
        if (br || jp) begin
            t = (br ? longint'(bt) : longint'(jt)) % pc_mod(k);
            if (t % STEP != 0) n.mis = 1'b1;
            n.pc = t - (t % STEP);
            if (n.cnt < cnt_max(k)) n.cnt = n.cnt + 1;
        end else if (!stall) begin
            n.pc = (s.pc + STEP) % pc_mod(k);
            if (n.cnt < cnt_max(k)) n.cnt = n.cnt + 1;
        end
        return n;
    endfunction

    function automatic bit exp_valid(int k);
        bit live = !m[k].halted;
`ifdef STEP_EN
        if (m[k].halted && step) live = 1'b1;
`endif
        return !rst && en && !stall && live;
    endfunction

    // Model state advances on the same edges as the design.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) m[k] <= reset_state(k);
            else     m[k] <= next_state(k, m[k]);
        end
    end

    task automatic chk(string name, longint unsigned act, longint unsigned exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_inst(int k, longint unsigned pc, longint unsigned pcp,
                              bit v, bit h, bit mi, longint unsigned c);
        chk($sformatf("u%0d pc", k), pc, m[k].pc);
        chk($sformatf("u%0d pc_plus", k), pcp, (m[k].pc + STEP) % pc_mod(k));
        chk($sformatf("u%0d valid", k), 64'(v), 64'(exp_valid(k)));
        chk($sformatf("u%0d halted", k), 64'(h), 64'(m[k].halted));
        chk($sformatf("u%0d misalign", k), 64'(mi), 64'(m[k].mis));
        chk($sformatf("u%0d fetch_cnt", k), c, m[k].cnt);
    endtask

    // Compare process: mid-cycle, away from the active edge.
    always @(negedge clk) begin
        #2;
        check_inst(0, 64'(pc0), 64'(pcp0), v0, h0, mi0, 64'(c0));
        check_inst(1, 64'(pc1), 64'(pcp1), v1, h1, mi1, 64'(c1));
    end

    task automatic drive(bit e, bit s, bit h, bit b, logic [31:0] btv,
                         bit j, logic [31:0] jtv, bit st);
        en = e; stall = s; halt = h; br = b; bt = btv; jp = j; jt = jtv; step = st;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held across two edges with enable already high.
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset pc", 64'(pc0), 64'h100);
        chk("reset valid", 64'(v0), 64'd0);
        chk("reset cnt", 64'(c0), 64'd0);
        rst = 1'b0;

        // Three sequential advances; the 8-bit instance wraps FC -> 00.
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
        chk("seq1 pc", 64'(pc0), 64'h104);
        chk("seq1 pc8", 64'(pc1), 64'hFC);
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
        chk("seq2 pc", 64'(pc0), 64'h108);
        chk("wrap pc8", 64'(pc1), 64'h00);
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
        chk("seq3 pc", 64'(pc0), 64'h10C);
        chk("seq3 cnt", 64'(c0), 64'd3);
        chk("seq3 pc8", 64'(pc1), 64'h04);

        // Stall holds PC and count.
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        chk("stall pc", 64'(pc0), 64'h10C);
        chk("stall valid", 64'(v0), 64'd0);
        chk("stall cnt", 64'(c0), 64'd3);

        // Redirect overrides stall; 2-bit counter saturates at 3.
        drive(1, 1, 0, 1, 32'h200, 0, 32'h0, 0);
        chk("br-over-stall pc", 64'(pc0), 64'h200);
        chk("br cnt", 64'(c0), 64'd4);
        chk("sat cnt2", 64'(c1), 64'd3);

        // Branch beats jump; then misaligned jump is masked and flagged.
        drive(1, 0, 0, 1, 32'h40, 1, 32'h80, 0);
        chk("br-prio pc", 64'(pc0), 64'h40);
        chk("aligned mis", 64'(mi0), 64'd0);
        drive(1, 0, 0, 0, 32'h0, 1, 32'h83, 0);
        chk("jmp mask pc", 64'(pc0), 64'h80);
        chk("jmp misalign", 64'(mi0), 64'd1);

        // Halt: PC frozen, redirects ignored.
        drive(1, 0, 1, 0, 32'h0, 0, 32'h0, 0);
        chk("halt flag", 64'(h0), 64'd1);
        chk("halt pc", 64'(pc0), 64'h80);
        drive(1, 0, 0, 1, 32'h300, 0, 32'h0, 0);
        chk("halt ignore pc", 64'(pc0), 64'h80);

        // Single step pulse while halted.
        en = 1'b1; br = 1'b0; step = 1'b1;
        #1;
`ifdef STEP_EN
        chk("step valid", 64'(v0), 64'd1);
`else
        chk("step valid", 64'(v0), 64'd0);
`endif
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 1);
`ifdef STEP_EN
        chk("step pc", 64'(pc0), 64'h84);
`else
        chk("step pc", 64'(pc0), 64'h80);
`endif
        chk("step halted", 64'(h0), 64'd1);
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);

        // Asynchronous reset mid-halt takes effect without a clock edge.
        rst = 1'b1;
        #1;
        chk("async rst pc", 64'(pc0), 64'h100);
        chk("async rst halted", 64'(h0), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rb, rj;
            rb = $urandom;
            rj = $urandom;
            if ($urandom_range(1, 0) == 0) rb[1:0] = 2'b00;
            if ($urandom_range(1, 0) == 0) rj[1:0] = 2'b00;
            if ($urandom_range(1, 0) == 0) rb[31:8] = 24'h0;
            rst = ($urandom_range(59, 0) == 0);
            drive(($urandom_range(7, 0) != 0), ($urandom_range(3, 0) == 0),
                  ($urandom_range(39, 0) == 0), ($urandom_range(5, 0) == 0), rb,
                  ($urandom_range(5, 0) == 0), rj, ($urandom_range(2, 0) == 0));
        end
        rst = 1'b0;
        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_pc_unit.md
Name: if_pc_unit

Overview:
Parametrised program-counter unit for the IF stage; successor to the fixed 32-bit PC register. It generates the fetch PC each cycle, selecting between sequential increment, branch redirect and jump redirect. Enable, stall and a sticky halt state machine gate updates. Fetched-PC count and a misalignment flag are exported to the debug unit.

Parameters:
PC_WIDTH, 32, width of all PC/target buses
RESET_PC, 0, PC value loaded on reset (must be PC_STEP-aligned)
PC_STEP, 4, sequential increment (power of two, ≥1)
CNT_WIDTH, 16, width of fetched-instruction counter

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  global run enable from debug unit; 0 = hold everything
i_stall  in  1  hazard stall from ID; hold PC
i_halt  in  1  HALT decoded; enter HALTED
i_branch_taken  in  1  branch redirect request
i_branch_target  in  PC_WIDTH  branch target
i_jump  in  1  jump redirect request
i_jump_target  in  PC_WIDTH  jump target
i_step  in  1  single-step pulse (used only with STEP_EN)
o_pc  out  PC_WIDTH  current fetch PC (registered)
o_pc_plus  out  PC_WIDTH  o_pc + PC_STEP (combinational from o_pc)
o_valid  out  1  o_pc is a live fetch this cycle
o_halted  out  1  state == HALTED
o_misalign  out  1  sticky: a redirect target had nonzero low log2(PC_STEP) bits
o_fetch_cnt  out  CNT_WIDTH  count of PC advances, saturating

Behaviour:
- Reset (async assert, sync release): o_pc=RESET_PC, state=RUN, o_valid=0, o_halted=0, o_misalign=0, o_fetch_cnt=0. o_valid becomes 1 on the first edge after release when in RUN with i_enable=1.
- States: RUN, HALTED. RUN→HALTED on an edge with i_halt=1 and i_enable=1; PC not updated on that edge. HALTED exits only via reset (or step, see optional feature).
- Next-PC priority per edge, in RUN with i_enable=1: i_branch_taken → branch target; else i_jump → jump target; else i_stall → hold; else o_pc+PC_STEP. A redirect overrides i_stall. i_halt overrides all of these.
- i_enable=0: PC, state, counter and flags hold; o_valid=0.
- HALTED: PC holds; o_valid=0; o_halted=1; redirect inputs are ignored.
- Alignment: redirect targets have low log2(PC_STEP) bits forced to 0 before loading. o_misalign is set if any forced bit was 1 and stays set until reset. With PC_STEP=1 no masking is applied and o_misalign stays 0.
- Arithmetic: PC increment wraps modulo 2^PC_WIDTH (max aligned PC → 0), with no flag.
- o_fetch_cnt increments on every edge where the PC register changes value or is reloaded by a redirect. A redirect to the current PC still counts. Stall and hold edges do not count. Counter saturates at all-ones.
- o_valid = (state==RUN) & i_enable & ~i_stall, as a registered-state-plus-input combinational output. A redirect cycle is valid.

Optional Feature:
STEP_EN. When defined, an i_step pulse in HALTED with i_enable=1 performs exactly one next-PC evaluation using the RUN priority rules (i_halt ignored). o_valid=1 for that cycle and o_fetch_cnt increments; the unit remains HALTED. If i_step is held high, it advances one PC per edge. When undefined, the i_step port is present but ignored, and HALTED is left only by reset.

Test Plan:
- Reset with PC_STEP=4, RESET_PC=0x100; release, i_enable=1 for 3 edges → o_pc 0x104, 0x108, 0x10C; o_fetch_cnt=3.
- i_stall=1 for 2 edges at o_pc=0x10C → o_pc holds 0x10C, o_valid=0, count unchanged. Then i_stall=1 with i_branch_taken=1, target 0x200 → o_pc=0x200 next edge.
- i_branch_taken=1 (target 0x40) and i_jump=1 (target 0x80) on the same edge → o_pc=0x40. Then jump target 0x83 → o_pc=0x80, o_misalign=1.
- i_halt=1 at o_pc=0x80 → o_halted=1, o_pc stays 0x80, later redirects are ignored. Assert i_reset mid-halt → o_pc=RESET_PC immediately (async), o_halted=0.
- PC_WIDTH=8, PC_STEP=4, o_pc=0xFC, one advance → o_pc=0x00. CNT_WIDTH=2: 4 advances → o_fetch_cnt=3 (saturated).
- With STEP_EN, halted at 0x80: one i_step pulse → o_pc=0x84, o_valid=1 for one cycle, still halted. Without STEP_EN, the same pulse → no change.
